// File: rtl/aes_dec_top.sv
// Iterative AES-128 decryption core: forward key expansion to RK10, then inverse rounds with on-the-fly inverse key schedule.
// Optional RK10 key cache enabled by defining AES_DEC_KEYCACHE_EN.
package aes_dec_pkg;
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction
endpackage

module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    import aes_dec_pkg::*;
    logic [7:0] w_inv;
    assign w_inv  = gf_inv(i_byte);
    assign o_byte = w_inv ^ rotl8(w_inv, 1) ^ rotl8(w_inv, 2) ^ rotl8(w_inv, 3) ^ rotl8(w_inv, 4) ^ 8'h63;
endmodule

module aes_inv_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    import aes_dec_pkg::*;
    logic [7:0] w_pre;
    assign w_pre  = rotl8(i_byte, 1) ^ rotl8(i_byte, 3) ^ rotl8(i_byte, 6) ^ 8'h05;
    assign o_byte = gf_inv(w_pre);
endmodule

module aes_dec_top (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] ciphertext,
    output logic         busy,
    output logic         done,
    output logic [127:0] plaintext
);
    import aes_dec_pkg::*;

    typedef enum logic [1:0] {IDLE, EXPAND, ADDKEY, ROUND} state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [127:0] r_rk;
    logic [127:0] r_st;
    logic [3:0]   r_cnt;
    logic [3:0]   r_rnd;
    logic         r_busy;
    logic         r_done;
    logic [127:0] r_plain;
    logic         w_hit;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Byte b sits at bits [127-8b -: 8]; row r, column c is byte 4c+r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Key schedule: one shared SubWord serves both the forward and inverse steps.
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_v1, w_v2, w_v3;
    logic [31:0]  w_sb_in, w_sb_out, w_rcon_word;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [3:0]   w_rcon_idx;
    logic [127:0] w_rk_fwd, w_rk_inv;

    assign w_w0 = r_rk[127:96];
    assign w_w1 = r_rk[95:64];
    assign w_w2 = r_rk[63:32];
    assign w_w3 = r_rk[31:0];
    assign w_v3 = w_w3 ^ w_w2;
    assign w_v2 = w_w2 ^ w_w1;
    assign w_v1 = w_w1 ^ w_w0;

    assign w_sb_in     = (r_state == EXPAND) ? {w_w3[23:0], w_w3[31:24]} : {w_v3[23:0], w_v3[31:24]};
    assign w_rcon_idx  = (r_state == EXPAND) ? r_cnt : ((r_state == ADDKEY) ? 4'd10 : r_rnd);
    assign w_rcon_word = {rcon(w_rcon_idx), 24'h000000};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_ks_sbox
            aes_sbox u_sbox (
                .i_byte (w_sb_in[31-8*g -: 8]),
                .o_byte (w_sb_out[31-8*g -: 8])
            );
        end
    endgenerate

    assign w_n0     = w_w0 ^ w_sb_out ^ w_rcon_word;
    assign w_n1     = w_w1 ^ w_n0;
    assign w_n2     = w_w2 ^ w_n1;
    assign w_n3     = w_w3 ^ w_n2;
    assign w_rk_fwd = {w_n0, w_n1, w_n2, w_n3};
    assign w_rk_inv = {w_w0 ^ w_sb_out ^ w_rcon_word, w_v1, w_v2, w_v3};

    // Round datapath
    logic [127:0] w_isr, w_isb, w_ark, w_round;

    assign w_isr = inv_shift_rows(r_st);

    generate
        for (g = 0; g < 16; g++) begin : g_inv_sbox
            aes_inv_sbox u_inv_sbox (
                .i_byte (w_isr[127-8*g -: 8]),
                .o_byte (w_isb[127-8*g -: 8])
            );
        end
    endgenerate

    assign w_ark   = w_isb ^ r_rk;
    assign w_round = (r_rnd == 4'd0) ? w_ark : inv_mix_columns(w_ark);

`ifdef AES_DEC_KEYCACHE_EN
    logic [127:0] r_key;
    logic [127:0] r_cache_key;
    logic [127:0] r_cache_rk10;
    logic         r_cache_vld;

    assign w_hit = r_cache_vld && (key == r_cache_key);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key        <= '0;
            r_cache_key  <= '0;
            r_cache_rk10 <= '0;
            r_cache_vld  <= 1'b0;
        end else begin
            if (r_state == IDLE && start) r_key <= key;
            if (r_state == EXPAND && r_cnt == 4'd10) begin
                r_cache_key  <= r_key;
                r_cache_rk10 <= w_rk_fwd;
                r_cache_vld  <= 1'b1;
            end
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = w_hit ? ADDKEY : EXPAND;
            EXPAND:  if (r_cnt == 4'd10) w_state_nxt = ADDKEY;
            ADDKEY:  w_state_nxt = ROUND;
            ROUND:   if (r_rnd == 4'd0) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rk    <= '0;
            r_st    <= '0;
            r_cnt   <= '0;
            r_rnd   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_plain <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
`ifdef AES_DEC_KEYCACHE_EN
                        r_rk <= w_hit ? r_cache_rk10 : key;
`else
                        r_rk <= key;
`endif
                        r_st   <= ciphertext;
                        r_busy <= 1'b1;
                        r_cnt  <= 4'd1;
                    end
                end
                EXPAND: begin
                    r_rk  <= w_rk_fwd;
                    r_cnt <= r_cnt + 4'd1;
                end
                ADDKEY: begin
                    r_st  <= r_st ^ r_rk;
                    r_rk  <= w_rk_inv;
                    r_rnd <= 4'd9;
                end
                ROUND: begin
                    r_st <= w_round;
                    if (r_rnd != 4'd0) begin
                        r_rk  <= w_rk_inv;
                        r_rnd <= r_rnd - 4'd1;
                    end else begin
                        r_plain <= w_round;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign plaintext = r_plain;
endmodule
